// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter with a zero-fill clear sequencer.
// Define FIXED_PRIORITY_EN for fixed (lowest index) priority instead of round-robin.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      Clock,
  input  logic                      CleanAllControl,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic [NUM_REQ-1:0]        ReqReady,
  input  logic                      ClearStart,
  output logic                      ClearBusy,
  output logic                      WriteControl,
  output logic [ADDR_W-1:0]         WriteRegAddress,
  output logic [DATA_W-1:0]         DataOfWrite
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_REG = '1;

  typedef enum logic {
    ST_ARB,
    ST_CLEAR
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  logic                w_found;
  logic [IW-1:0]       w_gnt_idx;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;

`ifdef FIXED_PRIORITY_EN
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (ReqValid[k]) begin
        w_found   = 1'b1;
        w_gnt_idx = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] r_last;

  // Search starts just past the last winner and wraps.
  always_comb begin
    int v_idx;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    v_idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = int'(r_last) + k;
      if (v_idx >= NUM_REQ) begin
        v_idx = v_idx - NUM_REQ;
      end
      if (!w_found && ReqValid[v_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = IW'(v_idx);
      end
    end
  end

  always_ff @(posedge Clock or negedge CleanAllControl) begin
    if (!CleanAllControl) begin
      r_last <= IW'(NUM_REQ - 1);
    end else if (w_xfer) begin
      r_last <= w_gnt_idx;
    end
  end
`endif

  assign w_xfer = w_found
                & (r_state == ST_ARB)
                & ~ClearStart;

  assign w_sel_addr =
    ReqAddr[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_sel_data =
    ReqData[w_gnt_idx*DATA_W +: DATA_W];

  assign ReqReady = w_xfer
    ? (NUM_REQ'(1) << w_gnt_idx)
    : '0;

  always_ff @(posedge Clock or negedge CleanAllControl) begin
    if (!CleanAllControl) begin
      r_state   <= ST_ARB;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      unique case (r_state)
        ST_ARB: begin
          if (ClearStart) begin
            r_state <= ST_CLEAR;
            r_cnt   <= ADDR_W'(1);
            r_wr_en <= 1'b0;
          end else if (w_xfer && (w_sel_addr != '0)) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
          end else begin
            // Idle, or an accepted write to r0 that is dropped.
            r_wr_en <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_cnt;
          r_wr_data <= '0;
          if (r_cnt == LAST_REG) begin
            r_state <= ST_ARB;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_ARB;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign ClearBusy       = (r_state == ST_CLEAR);
  assign WriteControl    = r_wr_en;
  assign WriteRegAddress = r_wr_addr;
  assign DataOfWrite     = r_wr_data;

  a_gnt_onehot: assert property (
    @(posedge Clock) disable iff (!CleanAllControl)
    $onehot0(ReqReady)
  );

  a_gnt_valid: assert property (
    @(posedge Clock) disable iff (!CleanAllControl)
    (ReqReady & ~ReqValid) == '0
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter.
// Reference model tracks grants, clears and expected writes by cycle.
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            Clock;
  logic            CleanAllControl;
  logic [N-1:0]    ReqValid;
  logic [N*AW-1:0] ReqAddr;
  logic [N*DW-1:0] ReqData;
  logic [N-1:0]    ReqReady;
  logic            ClearStart;
  logic            ClearBusy;
  logic            WriteControl;
  logic [AW-1:0]   WriteRegAddress;
  logic [DW-1:0]   DataOfWrite;

  regfile_write_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .Clock(Clock),
    .CleanAllControl(CleanAllControl),
    .ReqValid(ReqValid),
    .ReqAddr(ReqAddr),
    .ReqData(ReqData),
    .ReqReady(ReqReady),
    .ClearStart(ClearStart),
    .ClearBusy(ClearBusy),
    .WriteControl(WriteControl),
    .WriteRegAddress(WriteRegAddress),
    .DataOfWrite(DataOfWrite)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Reference model state
  int            m_last;
  int            busy_left;
  int            mode;
  logic          pend [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic int pick(logic [N-1:0] v);
`ifdef FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected writes whenever the DUT issues one.
  always @(negedge Clock) begin
    if (CleanAllControl === 1'b1) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_write: addr %0d due cycle %0d now %0d",
                 sb[0].addr, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (WriteControl === 1'b1) begin
        wr_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %0d data %h cycle %0d",
                   WriteRegAddress, DataOfWrite, cyc);
        end else begin
          e = sb.pop_front();
          if (WriteRegAddress !== e.addr || DataOfWrite !== e.data ||
              e.cyc != cyc) begin
            errors++;
            $display("FAIL write: got (%0d,%h)@%0d expected (%0d,%h)@%0d",
                     WriteRegAddress, DataOfWrite, cyc,
                     e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic drive(input logic cs);
    for (int i = 0; i < N; i++) begin
      ReqValid[i] = pend[i];
      ReqAddr[i*AW +: AW] = p_addr[i];
      ReqData[i*DW +: DW] = p_data[i];
    end
    ClearStart = cs;
  endtask

  task automatic step(input logic cs);
    logic [N-1:0] v;
    logic [N-1:0] eg;
    int w;
    @(posedge Clock);
    #1;
    drive(cs);
    #2;
    for (int i = 0; i < N; i++) v[i] = pend[i];
    chk("clear_busy", 64'(ClearBusy), 64'(busy_left > 0));
    eg = '0;
    w  = -1;
    if (busy_left == 0 && !cs) begin
      w = pick(v);
      if (w >= 0) eg[w] = 1'b1;
    end
    chk("req_ready", 64'(ReqReady), 64'(eg));
    if (w >= 0) begin
      m_last = w;
      pend[w] = 1'b0;
      if (p_addr[w] != 0)
        sb.push_back('{p_addr[w], p_data[w], cyc + 1});
    end
    if (busy_left > 0) begin
      busy_left--;
    end else if (cs) begin
      busy_left = 31;
      for (int k = 1; k <= 31; k++)
        sb.push_back('{AW'(k), '0, cyc + 1 + k});
    end
    for (int i = 0; i < N; i++) begin
      if (mode == 1 && w == i) begin
        pend[i] = 1'b1;
      end else if (mode == 2 && !pend[i] && $urandom_range(0, 1) == 1) begin
        pend[i]   = 1'b1;
        p_addr[i] = AW'($urandom_range(0, 31));
        p_data[i] = $urandom;
      end
    end
  endtask

  task automatic clr_pend();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    CleanAllControl = 1'b0;
    clr_pend();
    drive(1'b0);
    #1;
    chk("rst_wc", 64'(WriteControl), 64'd0);
    chk("rst_busy", 64'(ClearBusy), 64'd0);
    chk("rst_addr", 64'(WriteRegAddress), 64'd0);
    chk("rst_data", 64'(DataOfWrite), 64'd0);
    sb.delete();
    m_last    = N - 1;
    busy_left = 0;
    @(posedge Clock);
    #1;
    CleanAllControl = 1'b1;
  endtask

  initial begin
    CleanAllControl = 1'b0;
    ReqValid   = '0;
    ReqAddr    = '0;
    ReqData    = '0;
    ClearStart = 1'b0;
    mode       = 0;
    m_last     = N - 1;
    busy_left  = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      p_addr[i] = '0;
      p_data[i] = '0;
    end
    repeat (2) @(posedge Clock);
    do_reset();
    chk("rst_ready", 64'(ReqReady), 64'd0);

    // Three requesters held continuously
    mode = 1;
    for (int i = 0; i < N; i++) begin
      pend[i]   = 1'b1;
      p_addr[i] = AW'(5 + i);
      p_data[i] = 32'hA000_0000 + DW'(i);
    end
    repeat (4) step(1'b0);
    mode = 0;
    clr_pend();
    step(1'b0);

    // Single request from requester 1
    pend[1] = 1'b1;
    p_addr[1] = 5'd9;
    p_data[1] = 32'hDEADBEEF;
    repeat (3) step(1'b0);

    // Write to r0 is accepted then dropped
    pend[0] = 1'b1;
    p_addr[0] = 5'd0;
    p_data[0] = 32'h1234;
    repeat (3) step(1'b0);

    // Clear with a request pending
    pend[0] = 1'b1;
    p_addr[0] = 5'd4;
    p_data[0] = 32'h0BAD_F00D;
    step(1'b1);
    repeat (31) step(1'b0);
    repeat (3) step(1'b0);

    // ClearStart re-pulsed mid-sequence
    step(1'b1);
    repeat (9) step(1'b0);
    step(1'b1);
    repeat (25) step(1'b0);

    // Reset during clear
    step(1'b1);
    repeat (14) step(1'b0);
    do_reset();
    pend[2] = 1'b1;
    p_addr[2] = 5'd17;
    p_data[2] = 32'h5555_AAAA;
    repeat (3) step(1'b0);

    // Randomized traffic with occasional clears
    mode = 2;
    for (int c = 0; c < 500; c++)
      step($urandom_range(0, 59) == 0);
    mode = 0;
    repeat (45) step(1'b0);
    clr_pend();
    repeat (3) step(1'b0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d writes outstanding, expected 0",
               sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 31x32 general register file (r0 hard-wired to zero) between NUM_REQ writeback sources, for example ALU, load unit and debug. It arbitrates round-robin with a valid/ready handshake and registers the winning write onto the register-file write port. It also contains a clear sequencer that zeroes r1..r31 one register per cycle on request. It sits between the writeback sources and the register file's write address, write data and write-enable inputs.

Parameters:
NUM_REQ, 3, number of write requesters (2..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
Clock  in  1  rising-edge clock
CleanAllControl  in  1  asynchronous active-low reset
ReqValid  in  NUM_REQ  per-requester write request
ReqAddr  in  NUM_REQ*ADDR_W  packed request addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
ReqData  in  NUM_REQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W]
ReqReady  out  NUM_REQ  grant/accept, one-hot or zero, combinational
ClearStart  in  1  single-cycle pulse requesting a zero-fill of r1..r31
ClearBusy  out  1  clear sequence in progress
WriteControl  out  1  register-file write enable, registered
WriteRegAddress  out  ADDR_W  register-file write address, registered
DataOfWrite  out  DATA_W  register-file write data, registered

Behaviour:
- Reset (CleanAllControl=0, asynchronous):
  - WriteControl=0, WriteRegAddress=0, DataOfWrite=0, ClearBusy=0.
  - State=ARB; round-robin pointer Last=NUM_REQ-1, so requester 0 has first priority; clear counter=0.
- States:
  - ARB (default).
  - CLEAR.
- ARB, arbitration:
  - Search ReqValid starting at index (Last+1) mod NUM_REQ, wrapping. The first set bit i wins.
  - ReqReady[i]=1 combinationally; all other ReqReady bits are 0.
  - Transfer happens when ReqValid[i] & ReqReady[i].
  - On a transfer, Last<=i.
  - With no valid requests: ReqReady=0 and Last is unchanged.
- Requester rule: once ReqValid is asserted, it stays high with ReqAddr/ReqData stable until accepted.
- Write latency: a transfer at edge N produces WriteControl=1, WriteRegAddress=ReqAddr[i], DataOfWrite=ReqData[i] for exactly the cycle after edge N. The register file samples it at edge N+1.
- Idle cycles: WriteControl=0. Address and data hold their last values.
- Address 0: the request is accepted (ReqReady=1, Last updates) but WriteControl stays 0. The write is silently dropped.
- Throughput: one write per cycle. The arbiter never sees backpressure from the register file.
- ClearStart in ARB:
  - ClearStart has priority over requests. In that cycle ReqReady=0 for all requesters and no transfer happens.
  - Next state is CLEAR; counter<=1.
- CLEAR:
  - ClearBusy=1 and ReqReady=0 throughout.
  - Each cycle drives WriteControl=1, WriteRegAddress=counter, DataOfWrite=0, then counter increments.
  - Writes r1..r31 over 31 consecutive cycles.
  - After the edge that issues address 31, state returns to ARB and ClearBusy falls the same edge.
  - ClearStart during CLEAR is ignored; the sequence is not restarted.
  - Last is unchanged by a clear.
- Reset mid-CLEAR: the sequence aborts immediately and outputs take their reset values. No resume.
- Timing of the first write after clear: requests pending through CLEAR are arbitrated on the first ARB cycle. Their writes appear the cycle after that.

Optional Feature:
FIXED_PRIORITY_EN
- Defined:
  - Arbitration is fixed priority, lowest index wins. Requester 0 always beats 1, which beats 2.
  - Last is not implemented and not updated.
- Undefined:
  - Round-robin as described in Behaviour.
- All other behaviour (clear, address-0 drop, latency) is identical in both builds.

Test Plan:
- Reset, then ReqValid=3'b111 held continuously with addresses 5/6/7 and data A/B/C:
  - ReqReady sequence is 001, 010, 100, 001.
  - Writes appear one cycle later: (5,A), (6,B), (7,C), (5,A).
  - With FIXED_PRIORITY_EN: ReqReady stays 001 every cycle.
- Single request ReqValid=3'b010, addr=9, data=0xDEADBEEF:
  - ReqReady[1]=1 in the same cycle.
  - Next cycle: WriteControl=1, WriteRegAddress=9, DataOfWrite=0xDEADBEEF.
  - Following cycle: WriteControl=0.
- Request to addr 0 with data 0x1234:
  - Accepted (ReqReady=1).
  - WriteControl stays 0 for the next 2 cycles.
- ClearStart pulse while ReqValid=3'b001, addr=4:
  - ReqReady=0 for 32 cycles (the ClearStart cycle plus 31 clear cycles).
  - Writes (1,0)..(31,0) on consecutive cycles; ClearBusy high for exactly 31 cycles.
  - Requester 0 is then granted, and (4,data) is written on the next cycle.
- ClearStart re-pulsed at clear cycle 10: no restart; the sequence still ends after address 31 with no extra writes.
- CleanAllControl pulsed low at clear cycle 15:
  - Immediately WriteControl=0 and ClearBusy=0.
  - After release, ReqValid=3'b100 is granted to requester 2, since Last was reset to 2 and the search starts at 0.
